// File: rtl/score_keeper.sv
// score_keeper: 4-digit BCD game score with persistent high score and IDLE/PLAY/CMP/OVER control.
// Ports:
//   clk                    rising-edge clock
//   rst_n                  asynchronous reset, active-high despite its name
//   game_start             pulse: begin a new game (from IDLE or OVER)
//   score_inc              pulse: add one to the score while playing
//   game_over              pulse: end the game, compare against the high score
//   number_0..number_3     current score digits, thousands..units
//   highest_0..highest_3   high score digits, thousands..units
//   score_show             digit display enable (every state but IDLE)
//   new_high               one-cycle pulse when the high score is replaced
//   saturated              current score is 9999
module score_keeper (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       game_start,
   input  logic       score_inc,
   input  logic       game_over,
   output logic [3:0] number_0,
   output logic [3:0] number_1,
   output logic [3:0] number_2,
   output logic [3:0] number_3,
   output logic [3:0] highest_0,
   output logic [3:0] highest_1,
   output logic [3:0] highest_2,
   output logic [3:0] highest_3,
   output logic       score_show,
   output logic       new_high,
   output logic       saturated
);
   typedef enum logic [1:0] {IDLE, PLAY, CMP, OVER} state_t;
   state_t      state_q, state_d;
   logic [15:0] num_q, num_d, num_inc, hi_q, hi_d;
   logic        show_q, show_d, new_high_q, new_high_d, sat_q, sat_d, armed_q, armed_d;
   logic        start, inc, over, carry;
   always_comb begin
      // armed_q is low for the first edge after reset release so coinciding pulses are dropped
      start = game_start & armed_q;
      inc = score_inc & armed_q;
      over = game_over & armed_q;
      carry = 1'b1;
      num_inc = num_q;
      for (int i = 0; i < 4; i++) begin
         num_inc[4*i +: 4] = carry ? ((num_q[4*i +: 4] == 4'd9) ? 4'd0 : num_q[4*i +: 4] + 4'd1) : num_q[4*i +: 4];
         carry = carry & (num_q[4*i +: 4] == 4'd9);
      end
      state_d = state_q;
      num_d = num_q;
      hi_d = hi_q;
      new_high_d = 1'b0;
      armed_d = 1'b1;
      case (state_q)
         IDLE: if (start) begin
            state_d = PLAY;
            num_d = '0;
         end
         PLAY: begin
            if (inc && num_q != 16'h9999) num_d = num_inc;
            if (over) state_d = CMP;
         end
         CMP: begin
            state_d = OVER;
            // packed BCD with valid digits orders the same as plain binary
            if (num_q > hi_q) begin
               hi_d = num_q;
               new_high_d = 1'b1;
            end
         end
         OVER: if (start) begin
            state_d = PLAY;
            num_d = '0;
         end
         default: state_d = IDLE;
      endcase
      show_d = state_d != IDLE;
      sat_d = num_d == 16'h9999;
   end
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q <= IDLE;
         num_q <= '0;
         hi_q <= '0;
         show_q <= 1'b0;
         new_high_q <= 1'b0;
         sat_q <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         num_q <= num_d;
         hi_q <= hi_d;
         show_q <= show_d;
         new_high_q <= new_high_d;
         sat_q <= sat_d;
         armed_q <= armed_d;
      end
   end
   assign {number_0, number_1, number_2, number_3} = num_q;
   assign {highest_0, highest_1, highest_2, highest_3} = hi_q;
   assign score_show = show_q;
   assign new_high = new_high_q;
   assign saturated = sat_q;
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: randomized and directed stimulus against a decimal reference model, scoreboard-checked.
module tb_score_keeper;
   logic       clk = 1'b0, rst_n = 1'b0, game_start = 1'b0, score_inc = 1'b0, game_over = 1'b0;
   logic [3:0] number_0, number_1, number_2, number_3, highest_0, highest_1, highest_2, highest_3;
   logic       score_show, new_high, saturated;
   typedef struct {int score; int high; bit show; bit nh; bit sat;} exp_t;
   exp_t q[$];
   int   checks = 0, errors = 0;
   int   m_state = 0, m_score = 0, m_high = 0;
   bit   m_nh = 0, m_ignore = 0;
   always #5 clk = ~clk;
   score_keeper dut (
      .clk(clk), .rst_n(rst_n), .game_start(game_start), .score_inc(score_inc), .game_over(game_over),
      .number_0(number_0), .number_1(number_1), .number_2(number_2), .number_3(number_3),
      .highest_0(highest_0), .highest_1(highest_1), .highest_2(highest_2), .highest_3(highest_3),
      .score_show(score_show), .new_high(new_high), .saturated(saturated)
   );
   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // Decimal model: states 0=IDLE 1=PLAY 2=CMP 3=OVER; one call per clock edge.
   task automatic step(input bit gs, input bit si, input bit go, input bit rel = 0);
      exp_t e;
      @(negedge clk);
      if (rel) rst_n = 1'b0;
      game_start = gs;
      score_inc = si;
      game_over = go;
      if (m_ignore) begin
         gs = 0;
         si = 0;
         go = 0;
         m_ignore = 0;
      end
      m_nh = 0;
      case (m_state)
         0: if (gs) begin m_state = 1; m_score = 0; end
         1: begin
            if (si && m_score < 9999) m_score++;
            if (go) m_state = 2;
         end
         2: begin
            if (m_score > m_high) begin m_high = m_score; m_nh = 1; end
            m_state = 3;
         end
         default: if (gs) begin m_state = 1; m_score = 0; end
      endcase
      e.score = m_score;
      e.high = m_high;
      e.show = m_state != 0;
      e.nh = m_nh;
      e.sat = m_score == 9999;
      q.push_back(e);
      @(posedge clk);
      #2;
      game_start = 0;
      score_inc = 0;
      game_over = 0;
   endtask
   task automatic do_reset();
      #1;
      rst_n = 1'b1;
      #1;
      check("reset_async", {number_0, number_1, number_2, number_3, highest_0, highest_1, highest_2, highest_3, score_show, new_high, saturated}, 0);
      m_state = 0;
      m_score = 0;
      m_high = 0;
      m_nh = 0;
      game_start = 1;
      score_inc = 1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_held", {number_0, number_1, number_2, number_3, highest_0, highest_1, highest_2, highest_3, score_show, new_high, saturated}, 0);
      m_ignore = 1;
      step(1, 1, 0, 1);
   endtask
   task automatic play(input int n);
      for (int i = 0; i < n; i++) step(0, 1, 0);
   endtask
   task automatic finish_game();
      step(0, 0, 1);
      step(0, 0, 0);
      step(0, 0, 0);
   endtask
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("number", {number_0, number_1, number_2, number_3}, to_bcd(e.score));
            check("highest", {highest_0, highest_1, highest_2, highest_3}, to_bcd(e.high));
            check("score_show", score_show, e.show);
            check("new_high", new_high, e.nh);
            check("saturated", saturated, e.sat);
         end
      end
   end
   initial begin
      #2;
      do_reset();
      step(0, 1, 0);
      step(1, 0, 0);
      play(12);
      step(0, 0, 0);
      play(987);
      step(0, 1, 0);
      finish_game();
      @(posedge clk);
      do_reset();
      for (int g = 0; g < 3; g++) begin
         step(1, 0, 0);
         play(g == 2 ? 30 : 25);
         finish_game();
      end
      step(1, 0, 0);
      play(41);
      step(0, 1, 1);
      step(0, 0, 0);
      step(0, 0, 0);
      step(1, 0, 0);
      step(0, 1, 0);
      step(1, 0, 1);
      step(1, 1, 0);
      step(0, 0, 0);
      step(1, 0, 0);
      play(10005);
      step(1, 0, 0);
      finish_game();
      step(1, 0, 0);
      play(5);
      step(0, 0, 0);
      @(posedge clk);
      do_reset();
      play(500);
      finish_game();
      step(1, 0, 0);
      play(300);
      @(posedge clk);
      do_reset();
      for (int i = 0; i < 4; i++) step(0, 1, 0);
      step(1, 0, 0);
      play(3);
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      #3;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 The block SHALL have these ports: clk  input  1  system clock, all state on rising edge.
REQ-002 The block SHALL have these ports: rst_n  input  1  asynchronous reset, active-high (asserted when 1).
REQ-003 The block SHALL have these ports: game_start  input  1  one-cycle pulse, begin new game.
REQ-004 The block SHALL have these ports: score_inc  input  1  one-cycle pulse, bird passed one pipe.
REQ-005 The block SHALL have these ports: game_over  input  1  one-cycle pulse, collision detected.
REQ-006 The block SHALL have these ports: number_0..number_3  output  4 each  current score BCD digits; number_0 thousands, number_3 units.
REQ-007 The block SHALL have these ports: highest_0..highest_3  output  4 each  high score BCD digits; highest_0 thousands, highest_3 units.
REQ-008 The block SHALL have these ports: score_show  output  1  digit display enable, feeds the digit renderer's valid_in.
REQ-009 The block SHALL have these ports: new_high  output  1  one-cycle pulse when the high score is replaced.
REQ-010 The block SHALL have these ports: saturated  output  1  current score has reached 9999.
REQ-011 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Function
REQ-012 The FSM SHALL have four states, IDLE, PLAY, CMP and OVER, with these transitions:
- IDLE to PLAY on game_start.
- PLAY to CMP on game_over.
- CMP to OVER unconditionally after 1 cycle.
- OVER to PLAY on game_start.
REQ-013 On entry to PLAY (on the game_start edge), all number digits SHALL clear to 0 and saturated SHALL clear to 0.
REQ-014 In PLAY, each score_inc SHALL increment the 4-digit BCD score by 1, visible on the next cycle.
- Digit rolls over 9 to 0 and carries into the next more-significant digit.
- Example: 0199 becomes 0200; 0999 becomes 1000.
REQ-015 Every digit SHALL stay within 0-9 at all times; the block SHALL never produce 4'hA-4'hF.
REQ-016 At score 9999, further score_inc SHALL be ignored, the score SHALL hold at 9999, and saturated SHALL be 1.
REQ-017 score_inc in IDLE, CMP or OVER SHALL be ignored.
REQ-018 game_start in PLAY or CMP SHALL be ignored.
REQ-019 If score_inc and game_over are asserted in the same PLAY cycle, the increment SHALL be applied and CMP SHALL compare the incremented score.
REQ-020 In PLAY, game_over SHALL take priority over game_start when both are asserted in the same cycle.
REQ-021 In CMP, the current score SHALL be compared digit-wise as an unsigned BCD magnitude against the high score.
- If strictly greater: highest digits take the score value at the CMP-to-OVER edge, and new_high pulses 1 for exactly one cycle, the first OVER cycle.
- If equal or less: highest is unchanged and new_high stays 0.
REQ-022 The score SHALL hold its final value through CMP and OVER until the next game_start.
REQ-023 The high score SHALL persist across games and SHALL be cleared only by reset.
REQ-024 score_show SHALL be 0 in IDLE and 1 in PLAY, CMP and OVER.
REQ-025 The latency from any input pulse to its visible effect on the outputs SHALL be exactly one clock.

Reset
REQ-026 While rst_n is 1, the block SHALL immediately, independent of clk:
- force state to IDLE;
- force all number_* and highest_* to 0;
- force score_show, new_high and saturated to 0.
REQ-027 Reset asserted mid-game (any state) SHALL discard the score and the high score, with no new_high pulse.
REQ-028 Input pulses SHALL be ignored while rst_n is 1 and on the first clk edge after deassertion if they coincide with it.

Verification
REQ-029 Basic count: reset, game_start, 12 score_inc pulses -> number_0..3 = 0,0,1,2; score_show = 1; highest = 0000.
REQ-030 Carry chain: drive the score to 0999, then 1 score_inc -> 1,0,0,0 one cycle later; no invalid digit at any cycle.
REQ-031 High-score update:
- game 1 scores 0025, then game_over -> after 2 cycles highest = 0025, with a single new_high pulse;
- game 2 scores 0025, then game_over -> highest stays 0025, no new_high;
- game 3 scores 0030 -> highest = 0030, new_high pulses.
REQ-032 Simultaneous events:
- score_inc and game_over in the same cycle at score 0041 -> final score 0042, compared and stored as 0042;
- game_start and game_over in the same PLAY cycle -> FSM goes to CMP.
REQ-033 Saturation: 10005 score_inc pulses -> score 9999, saturated = 1 from the 9999th pulse on; the next game_start clears the score and saturated.
REQ-034 Async reset: assert rst_n mid-clock-period in PLAY with score 0300 and highest 0500 -> all outputs 0 before the next clk edge, state IDLE, and score_inc ignored until game_start.
